// File: rtl/uart_pkg.sv
// Shared definitions for the UART command parser: FSM encoding, default sync
// marker and the bundle of one-cycle status pulses.
package uart_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_LEN = 3'd2,
        GET_PAY = 3'd3,
        GET_CHK = 3'd4
    } state_t;

    typedef struct packed {
        logic cmd_valid;
        logic err_chk;
        logic err_len;
        logic err_timeout;
        logic err_frame;
    } pulse_t;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle counter; expired strobes for one cycle when CYCLES enabled,
// uncleared clocks have elapsed.
module uart_byte_timer #(
    parameter int unsigned CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count;

    // A clear in the same cycle wins, so an arriving byte always beats the timeout.
    assign expired = enable && !clear && (count == W'(CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear || expired)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/CMD/LEN/payload/CHK frames from a byte stream, streams payload
// to a buffer and reports good frames or the reason a frame was dropped.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
    parameter int unsigned MAX_LEN        = 15,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_frame_error,
    output logic [7:0] cmd,
    output logic [3:0] cmd_len,
    output logic       pay_wr_en,
    output logic [3:0] pay_wr_addr,
    output logic [7:0] pay_wr_data,
    output logic       cmd_valid,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_frame,
    output logic       busy
);

    state_t     state, nxt;
    logic [7:0] cmd_sh;
    logic [3:0] len_sh;
    logic [7:0] xor_r;
    logic [3:0] idx;
    logic       expired;
    logic       take;
    logic       wr_en_d;
    pulse_t     pulse_d, pulse_q;

    // A frame error drops any byte presented alongside it.
    assign take = rx_valid && !rx_frame_error;

    uart_byte_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid || rx_frame_error || (state == IDLE)),
        .enable (state != IDLE),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (rx_frame_error || expired)
            nxt = IDLE;
        else if (rx_valid) begin
            case (state)
                IDLE:    if (rx_data == SYNC_BYTE) nxt = GET_CMD;
                GET_CMD: nxt = GET_LEN;
                GET_LEN: begin
                    if (rx_data > 8'(MAX_LEN))
                        nxt = IDLE;
                    else if (rx_data == 8'd0)
                        nxt = GET_CHK;
                    else
                        nxt = GET_PAY;
                end
                GET_PAY: if (idx == len_sh - 4'd1) nxt = GET_CHK;
                GET_CHK: nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pulse_d = '0;
        wr_en_d = 1'b0;
        if (rx_frame_error)
            pulse_d.err_frame = (state != IDLE);
        else if (expired)
            pulse_d.err_timeout = 1'b1;
        else if (rx_valid) begin
            case (state)
                GET_LEN: pulse_d.err_len = (rx_data > 8'(MAX_LEN));
                GET_PAY: wr_en_d = 1'b1;
                GET_CHK: begin
                    pulse_d.cmd_valid = (rx_data == xor_r);
                    pulse_d.err_chk   = (rx_data != xor_r);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_sh      <= '0;
            len_sh      <= '0;
            xor_r       <= '0;
            idx         <= '0;
            cmd         <= '0;
            cmd_len     <= '0;
            pay_wr_en   <= 1'b0;
            pay_wr_addr <= '0;
            pay_wr_data <= '0;
            pulse_q     <= '0;
        end else begin
            pulse_q   <= pulse_d;
            pay_wr_en <= wr_en_d;
            if (wr_en_d) begin
                pay_wr_addr <= idx;
                pay_wr_data <= rx_data;
            end
            if (take) begin
                case (state)
                    GET_CMD: begin
                        cmd_sh <= rx_data;
                        xor_r  <= rx_data;
                    end
                    GET_LEN: begin
                        xor_r  <= xor_r ^ rx_data;
                        len_sh <= rx_data[3:0];
                        idx    <= '0;
                    end
                    GET_PAY: begin
                        xor_r <= xor_r ^ rx_data;
                        idx   <= idx + 4'd1;
                    end
                    default: ;
                endcase
            end
            if (pulse_d.cmd_valid) begin
                cmd     <= cmd_sh;
                cmd_len <= len_sh;
            end
        end
    end

    assign cmd_valid   = pulse_q.cmd_valid;
    assign err_chk     = pulse_q.err_chk;
    assign err_len     = pulse_q.err_len;
    assign err_timeout = pulse_q.err_timeout;
    assign err_frame   = pulse_q.err_frame;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed frames for uart_cmd_parser; expected pulses are queued with their
// cycle of arrival and matched by an independent monitor.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_frame_error = 1'b0;
    logic [7:0] cmd;
    logic [3:0] cmd_len;
    logic       pay_wr_en;
    logic [3:0] pay_wr_addr;
    logic [7:0] pay_wr_data;
    logic       cmd_valid, err_chk, err_len, err_timeout, err_frame, busy;

    uart_cmd_parser #(.SYNC_BYTE(8'hAA), .MAX_LEN(15), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_error(rx_frame_error), .cmd(cmd), .cmd_len(cmd_len),
        .pay_wr_en(pay_wr_en), .pay_wr_addr(pay_wr_addr), .pay_wr_data(pay_wr_data),
        .cmd_valid(cmd_valid), .err_chk(err_chk), .err_len(err_len),
        .err_timeout(err_timeout), .err_frame(err_frame), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 write, 1 cmd_valid, 2 err_chk, 3 err_len, 4 err_timeout, 5 err_frame
    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] b;
        int         at;
    } ev_t;

    ev_t        q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cmd = 8'h00;
    logic [3:0] exp_len = 4'h0;
    logic [7:0] pl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int  mon_n;
    ev_t mon_a, mon_e;
    always @(negedge clk) begin
        mon_n = $countones({pay_wr_en, cmd_valid, err_chk, err_len, err_timeout, err_frame});
        if (mon_n != 0) begin
            check("pulse_onehot", mon_n, 1);
            mon_a.kind = pay_wr_en ? 0 : cmd_valid ? 1 : err_chk ? 2 :
                         err_len ? 3 : err_timeout ? 4 : 5;
            mon_a.a  = pay_wr_en ? {4'h0, pay_wr_addr} : cmd;
            mon_a.b  = pay_wr_en ? pay_wr_data : {4'h0, cmd_len};
            mon_a.at = cyc;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, none expected", mon_a.kind, cyc);
            end else begin
                mon_e = q.pop_front();
                check("ev_kind", mon_a.kind, mon_e.kind);
                check("ev_field_a", mon_a.a, mon_e.a);
                check("ev_field_b", mon_a.b, mon_e.b);
                check("ev_cycle", mon_a.at, mon_e.at);
            end
        end
    end

    task automatic push(input int kind, input logic [7:0] a, input logic [7:0] b, input int at);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.at = at;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, output int c);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        c = cyc;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] cm, input logic [7:0] ln, input logic [7:0] p[16],
                         input logic [7:0] ck, input bit good);
        int c;
        send(8'hAA, c);
        send(cm, c);
        send(ln, c);
        for (int i = 0; i < int'(ln); i++) begin
            send(p[i], c);
            push(0, 8'(i), p[i], c + 1);
        end
        send(ck, c);
        if (good) begin
            exp_cmd = cm;
            exp_len = ln[3:0];
            push(1, exp_cmd, {4'h0, exp_len}, c + 1);
        end else
            push(2, exp_cmd, {4'h0, exp_len}, c + 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_cmd_len"}, cmd_len, 0);
        check({tag, "_wr"}, {pay_wr_en, pay_wr_addr, pay_wr_data}, 0);
        check({tag, "_pulses"}, {cmd_valid, err_chk, err_len, err_timeout, err_frame}, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // noise and a frame error while idle: nothing expected
        send(8'h55, c);
        send(8'h10, c);
        @(negedge clk); rx_frame_error = 1'b1;
        @(posedge clk); #1 rx_frame_error = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        frame(8'h10, 8'h03, pl, 8'h13, 1'b1);
        frame(8'h21, 8'h00, pl, 8'h21, 1'b1);
        pl[0] = 8'h55;
        frame(8'h10, 8'h01, pl, 8'h00, 1'b0);
        @(negedge clk);
        check("chk_err_cmd_kept", {cmd, cmd_len}, {8'h21, 4'h0});

        // sync byte inside payload is plain data
        pl[0] = 8'hAA; pl[1] = 8'h55;
        frame(8'h30, 8'h02, pl, 8'hCD, 1'b1);

        // maximum length; XOR of 0..14 is 0F, so CHK equals CMD
        for (int i = 0; i < 16; i++) pl[i] = 8'(i);
        frame(8'h5A, 8'h0F, pl, 8'h5A, 1'b1);

        send(8'hAA, c); send(8'h10, c); send(8'h20, c);
        push(3, exp_cmd, {4'h0, exp_len}, c + 1);
        send(8'hAA, c); send(8'h10, c); send(8'h10, c);
        push(3, exp_cmd, {4'h0, exp_len}, c + 1);
        repeat (2) @(negedge clk);
        check("len_err_busy", busy, 0);

        send(8'hAA, c); send(8'h10, c);
        push(4, exp_cmd, {4'h0, exp_len}, c + 101);
        repeat (110) @(negedge clk);
        check("timeout_busy", busy, 0);

        // frame error coincident with a byte: byte dropped, frame aborted
        send(8'hAA, c); send(8'h10, c);
        @(negedge clk);
        rx_frame_error = 1'b1; rx_valid = 1'b1; rx_data = 8'h03; c = cyc;
        @(posedge clk); #1 begin rx_frame_error = 1'b0; rx_valid = 1'b0; end
        push(5, exp_cmd, {4'h0, exp_len}, c + 1);
        repeat (2) @(negedge clk);
        check("frame_err_busy", busy, 0);
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        frame(8'h10, 8'h03, pl, 8'h13, 1'b1);

        // reset mid-payload
        send(8'hAA, c); send(8'h77, c); send(8'h03, c); send(8'h01, c);
        push(0, 8'h00, 8'h01, c + 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        exp_cmd = 8'h00; exp_len = 4'h0;
        @(negedge clk); rst = 1'b0;
        frame(8'h21, 8'h00, pl, 8'h21, 1'b1);

        repeat (5) @(negedge clk);
        check("final_cmd", {cmd, cmd_len}, {8'h21, 4'h0});
        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 The parameter list SHALL be exactly: SYNC_BYTE, default 8'hAA, frame start marker.
REQ-002 The parameter list SHALL include: MAX_LEN, default 15, maximum accepted payload length, 1..15.
REQ-003 The parameter list SHALL include: TIMEOUT_CYCLES, default 50000, idle clocks allowed between bytes inside a frame (1 ms at 50 MHz).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 The port list SHALL begin: clk  in  1  system clock, 50 MHz.
REQ-006 Port: rst  in  1  asynchronous reset, active high.
REQ-007 Port: rx_data  in  8  byte from the upstream UART receiver.
REQ-008 Port: rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-009 Port: rx_frame_error  in  1  one-cycle strobe for an upstream stop-bit error.
REQ-010 Port: cmd  out  8  command byte of the last good frame.
REQ-011 Port: cmd_len  out  4  payload length of the last good frame.
REQ-012 Port: pay_wr_en  out  1  payload buffer write strobe.
REQ-013 Port: pay_wr_addr  out  4  payload buffer write address.
REQ-014 Port: pay_wr_data  out  8  payload buffer write data.
REQ-015 Port: cmd_valid  out  1  one-cycle pulse for a good frame.
REQ-016 Port: err_chk, err_len, err_timeout, err_frame  out  1 each  one-cycle error pulses.
REQ-017 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-018 Frame format SHALL be: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK, where CHK = XOR of CMD, LEN and all payload bytes.
REQ-019 The FSM states SHALL be IDLE, GET_CMD, GET_LEN, GET_PAY and GET_CHK.
REQ-020 The FSM SHALL advance only on cycles where rx_valid=1.
REQ-021 IDLE: on a byte equal to SYNC_BYTE -> GET_CMD; any other byte is discarded with no pulse.
REQ-022 GET_CMD: latch the byte into a cmd shadow register, initialise the running XOR to the byte, -> GET_LEN.
REQ-023 GET_LEN: if the byte is greater than MAX_LEN -> pulse err_len, -> IDLE.
REQ-024 GET_LEN: if LEN=0, XOR the byte in and go directly to GET_CHK.
REQ-025 GET_LEN: otherwise XOR the byte in, clear the payload index, -> GET_PAY.
REQ-026 GET_PAY: each byte SHALL drive pay_wr_en=1, pay_wr_addr=index and pay_wr_data=byte on the cycle after rx_valid, and be XORed in.
REQ-027 GET_PAY: after the LEN-th byte (index = LEN-1) -> GET_CHK.
REQ-028 GET_CHK: if the byte equals the running XOR, pulse cmd_valid and update cmd/cmd_len from shadow on the same cycle; otherwise pulse err_chk; -> IDLE in both cases.
REQ-029 Latency: cmd_valid or err_chk SHALL assert exactly 1 clock after the rx_valid of the CHK byte.
REQ-030 cmd and cmd_len SHALL hold their values until the next good frame and SHALL NOT change on error.
REQ-031 Timeout: an idle counter SHALL clear on every rx_valid and in IDLE.
REQ-032 Timeout: when the counter reaches TIMEOUT_CYCLES-1 outside IDLE, pulse err_timeout, -> IDLE.
REQ-033 rx_frame_error in any non-IDLE state SHALL pulse err_frame, -> IDLE; in IDLE it SHALL be ignored.
REQ-034 rx_frame_error and rx_valid asserted in the same cycle SHALL resolve as rx_frame_error, and the byte SHALL be dropped.
REQ-035 SYNC_BYTE values received in states other than IDLE SHALL be treated as ordinary data; there is no resynchronisation mid-frame.
REQ-036 All pulse outputs SHALL be registered and last exactly one clock.
REQ-037 At most one of cmd_valid or the err_* outputs SHALL be asserted in any cycle.
REQ-038 Payload already written for an aborted frame SHALL NOT be rolled back; consumers SHALL act only on cmd_valid.

Reset
REQ-039 Reset SHALL force state to IDLE and clear the counter, index and XOR.
REQ-040 Reset SHALL drive every output to 0: cmd, cmd_len, pay_wr_*, all pulses and busy.
REQ-041 Reset asserted mid-frame SHALL discard the frame with no error pulse, and parsing SHALL restart at the next SYNC_BYTE after release.

Structure
REQ-042 The FSM state encoding and the default SYNC_BYTE constant SHALL reside in the shared package uart_pkg.
REQ-043 The inter-byte timeout counter SHALL be a separate sub-module named uart_byte_timer, with inputs clear and enable and a one-cycle output expired.

Verification
REQ-044 Good frame AA 10 03 01 02 03 CHK=13 -> three writes to addr 0..2 with data 01,02,03, then cmd_valid with cmd=10 and cmd_len=3.
REQ-045 Zero-length frame AA 21 00 21 -> no pay_wr_en, cmd_valid with cmd=21 and cmd_len=0.
REQ-046 Bad checksum AA 10 01 55 00 -> err_chk, and cmd/cmd_len keep their previous values.
REQ-047 LEN error AA 10 20 -> err_len; with TIMEOUT_CYCLES=100, AA 10 followed by 100 idle clocks -> err_timeout; busy=0 after both.
REQ-048 Frame error and reset: rx_frame_error after AA 10 -> err_frame; rst mid-payload -> all outputs 0, and the next good frame is still parsed correctly.
